// File: rtl/serial_tx_uart_if.sv
// rtl/serial_tx_uart_if.sv - processor-side byte write handshake for serial_tx_uart
interface serial_tx_uart_if;
    logic [7:0] wr_data_in;
    logic       wr_en_in;
    logic       ready_out;

    modport master (output wr_data_in, output wr_en_in, input ready_out);
    modport slave  (input wr_data_in, input wr_en_in, output ready_out);
endinterface

// File: rtl/serial_tx_uart.sv
// rtl/serial_tx_uart.sv - FIFO-buffered UART transmitter, 8N1 (8E1 with SERIAL_TX_PARITY_EN)
module serial_tx_uart #(
    parameter int CLKS_PER_BIT = 434,
    parameter int FIFO_DEPTH   = 16
) (
    input  logic                        clock,
    input  logic                        reset,
    serial_tx_uart_if.slave             wr,
    output logic                        tx_out,
    output logic                        busy_out,
    output logic [$clog2(FIFO_DEPTH):0] count_out,
    output logic                        overflow_out
);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;
    localparam int TW = $clog2(CLKS_PER_BIT);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
`ifdef SERIAL_TX_PARITY_EN
        PARITY,
`endif
        STOP
    } state_t;

    state_t          state_q, state_d;
    logic [TW-1:0]   timer_q, timer_d;
    logic [2:0]      bit_idx_q, bit_idx_d;
    logic [7:0]      shift_q, shift_d;
    logic            tx_q, tx_d;
    logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]   count_q, count_d;
    logic            ovf_q, ovf_d;
    logic [7:0]      mem_q [FIFO_DEPTH];

    logic            ready;
    logic            push;
    logic            pop;
    logic            bit_end;
    logic [2:0]      next_idx;

    // ready comes from the pre-edge count, so a write at full is dropped even if a pop happens this cycle
    assign ready    = (count_q < CW'(FIFO_DEPTH));
    assign push     = wr.wr_en_in && ready;
    assign pop      = (state_q == IDLE) && (count_q != '0);
    assign bit_end  = (timer_q == TW'(CLKS_PER_BIT - 1));
    assign next_idx = bit_idx_q + 3'd1;

    always_comb begin
        state_d   = state_q;
        timer_d   = timer_q + TW'(1);
        bit_idx_d = bit_idx_q;
        shift_d   = shift_q;
        tx_d      = tx_q;
        wr_ptr_d  = push ? wr_ptr_q + PW'(1) : wr_ptr_q;
        rd_ptr_d  = pop ? rd_ptr_q + PW'(1) : rd_ptr_q;
        ovf_d     = ovf_q | (wr.wr_en_in & ~ready);
        count_d   = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase

        case (state_q)
            IDLE: begin
                timer_d = '0;
                tx_d    = 1'b1;
                if (pop) begin
                    shift_d   = mem_q[rd_ptr_q];
                    bit_idx_d = 3'd0;
                    state_d   = START;
                    tx_d      = 1'b0;
                end
            end
            START: begin
                if (bit_end) begin
                    timer_d = '0;
                    state_d = DATA;
                    tx_d    = shift_q[0];
                end
            end
            DATA: begin
                if (bit_end) begin
                    timer_d = '0;
                    if (bit_idx_q == 3'd7) begin
`ifdef SERIAL_TX_PARITY_EN
                        state_d = PARITY;
                        tx_d    = ^shift_q;
`else
                        state_d = STOP;
                        tx_d    = 1'b1;
`endif
                    end else begin
                        bit_idx_d = next_idx;
                        tx_d      = shift_q[next_idx];
                    end
                end
            end
`ifdef SERIAL_TX_PARITY_EN
            PARITY: begin
                if (bit_end) begin
                    timer_d = '0;
                    state_d = STOP;
                    tx_d    = 1'b1;
                end
            end
`endif
            STOP: begin
                if (bit_end) begin
                    timer_d = '0;
                    state_d = IDLE;
                    tx_d    = 1'b1;
                end
            end
            default: begin
                timer_d = '0;
                state_d = IDLE;
                tx_d    = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= IDLE;
            timer_q   <= '0;
            bit_idx_q <= 3'd0;
            shift_q   <= 8'h00;
            tx_q      <= 1'b1;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            ovf_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            timer_q   <= timer_d;
            bit_idx_q <= bit_idx_d;
            shift_q   <= shift_d;
            tx_q      <= tx_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            ovf_q     <= ovf_d;
        end
    end

    // Storage needs no reset: entries are only read after being written
    always_ff @(posedge clock) begin
        if (push) begin
            mem_q[wr_ptr_q] <= wr.wr_data_in;
        end
    end

    assign wr.ready_out = ready;
    assign tx_out       = tx_q;
    assign busy_out     = (state_q != IDLE) || (count_q != '0);
    assign count_out    = count_q;
    assign overflow_out = ovf_q;
endmodule

// File: doc/serial_tx_uart.md
# serial_tx_uart

Transmit-side serial port that sits directly downstream of the processor's memory-mapped serial output. Bytes the program stores to the serial port (`serial_out` qualified by `serial_wren_out`) are captured into a small FIFO and shifted out as asynchronous 8N1 UART frames on a single line. The block returns a ready indication to the processor (`serial_ready_in`) so software can poll before writing.

## Interface
Parameters:
- `CLKS_PER_BIT`, 434, clock cycles per UART bit; must be ≥ 2.
- `FIFO_DEPTH`, 16, byte entries; a power of two, ≥ 2.

Ports:
- `clock`, input, 1, system clock.
- `reset`, input, 1, synchronous, active-high.
- `wr_data_in`, input, 8, byte to transmit; connects to the processor's `serial_out`.
- `wr_en_in`, input, 1, write strobe, one cycle per byte; connects to `serial_wren_out`.
- `ready_out`, output, 1, FIFO not full; connects to the processor's `serial_ready_in`.
- `tx_out`, output, 1, UART line; idles high.
- `busy_out`, output, 1, high while a frame is on the line or the FIFO is non-empty.
- `count_out`, output, log2(FIFO_DEPTH)+1, current FIFO occupancy.
- `overflow_out`, output, 1, sticky; set when a write is dropped.

## Operation
- **Reset values:** `tx_out`=1, `ready_out`=1, `busy_out`=0, `count_out`=0, `overflow_out`=0. FIFO pointers are cleared and the FSM returns to IDLE.
- **FIFO:** circular buffer with read/write pointers of log2(FIFO_DEPTH) bits that wrap modulo depth, plus a separate occupancy counter.
  - Push occurs when `wr_en_in && ready_out`.
  - `ready_out` = (count < FIFO_DEPTH) and is evaluated on the pre-edge count.
  - A write while full is dropped even if a pop happens in the same cycle; the drop sets `overflow_out`.
  - Simultaneous push and pop with count ≥ 1 leaves count unchanged.
  - A pop never occurs when count = 0.
- **FSM states:** IDLE, START, DATA, PARITY (only when the macro is defined), STOP.
  - IDLE: if count > 0, pop the head byte into the shift register and go to START; otherwise hold `tx_out`=1.
  - START: `tx_out`=0 for CLKS_PER_BIT cycles, then DATA.
  - DATA: send bits LSB first, each for CLKS_PER_BIT cycles. A 3-bit index counts 0..7. After bit 7, go to PARITY or STOP.
  - STOP: `tx_out`=1 for CLKS_PER_BIT cycles, then IDLE.
- **Bit timer:** counts 0..CLKS_PER_BIT-1 and restarts on every state or bit change.
- **Outputs:** `tx_out` is registered, with no combinational path from inputs. `busy_out` = (state ≠ IDLE) || (count ≠ 0).

## Timing
- **Latency:** a byte written at edge N into an empty FIFO with the FSM in IDLE is popped at edge N+1. `tx_out` goes low after edge N+1.
- **Frame length:** 10×CLKS_PER_BIT cycles, or 11×CLKS_PER_BIT with parity.
- **Back-to-back frames:** STOP ends and IDLE pops in the next cycle. This gives a 1-cycle IDLE gap (idle-high) between frames.
- **Pop and count:** a pop updates `count_out` one edge after IDLE sees count > 0, so `ready_out` rises on the same edge.
- **Reset mid-frame:** on the next edge `tx_out`=1 and the FIFO is emptied. The partial frame is abandoned, and receivers see a truncated frame.
- **Writes during transmission:** buffered normally. The shift register holds the in-flight byte, so the FIFO holds up to FIFO_DEPTH further bytes.

## Configuration
- **`SERIAL_TX_PARITY_EN` defined:** the PARITY state is inserted after DATA. It drives the even-parity bit (XOR of the 8 data bits) for CLKS_PER_BIT cycles, making the frame 8E1.
- **Not defined:** the PARITY state and the XOR logic are absent, and frames are 8N1.
- Nothing else changes: FIFO behaviour, ports and latency are identical.

## Test plan
- **Reset:** assert reset for 2 cycles mid-frame → next edge `tx_out`=1, `count_out`=0, `busy_out`=0, `overflow_out`=0.
- **Single byte (CLKS_PER_BIT=4):** write 8'hA5 → `tx_out` sequence, each bit held 4 cycles: 0,1,0,1,0,0,1,0,1,1. Frame starts 1 cycle after the write.
- **Full FIFO (FIFO_DEPTH=4):** 5 consecutive writes 8'h01..8'h05 → first byte popped after 1 cycle, `ready_out` never low, 5 frames in order.
- **Overflow:** hold the FSM busy and write 6 bytes → `ready_out` low at count 4. The 6th write is dropped and `overflow_out`=1. Frames 1..5 carry correct data.
- **Push at full during pop:** write exactly on the edge where IDLE pops from a full FIFO → write dropped, `overflow_out`=1, count = DEPTH-1.
- **Parity (`SERIAL_TX_PARITY_EN`):** byte 8'h07 → parity bit 1 between bit 7 and stop. Frame length 11×CLKS_PER_BIT.
